// File: rtl/axis_stream_checker_if.sv
// axis_stream_checker_if: AXI-Stream beat signals between a source and the checker
interface axis_stream_checker_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] S_TData;
  logic S_TValid;
  logic S_TLast;
  logic S_TReady;
  modport master (output S_TData, output S_TValid, output S_TLast, input S_TReady);
  modport slave (input S_TData, input S_TValid, input S_TLast, output S_TReady);
endinterface

// File: rtl/axis_stream_checker.sv
// axis_stream_checker: AXI-Stream sink that checks countdown data and fixed packet length
// under a rotating ready mask, reporting saturating packet and error counts.
module axis_stream_checker #(
  parameter int WIDTH = 8,
  parameter int PKT_LEN = 8,
  parameter int SEED = 8,
  parameter int NUM_PKTS = 4,
  parameter logic [7:0] READY_MASK = 8'hFF
) (
  input  logic CLK,
  input  logic Reset_n,
  input  logic Enable,
  axis_stream_checker_if.slave s,
  output logic [15:0] PktCount,
  output logic [15:0] ErrCount,
  output logic DataErr,
  output logic LastErr,
  output logic Busy,
  output logic Done
);
  localparam int IW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  typedef enum logic [1:0] {IDLE, RECV, RESYNC, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0] pkt_q, pkt_d, err_q, err_d, pkt_inc;
  logic [16:0] err_sum;
  logic data_err_q, data_err_d, last_err_q, last_err_d;
  logic busy, hs, at_last, pkt_end;
  logic [WIDTH-1:0] exp_data;
  assign busy = state_q == RECV || state_q == RESYNC;
  // ready comes from flops only, never from S_TValid
  assign s.S_TReady = busy && mask_q[0];
  assign hs = s.S_TValid && s.S_TReady;
  assign at_last = idx_q == IW'(PKT_LEN - 1);
  assign exp_data = WIDTH'(SEED) - WIDTH'(idx_q);
  always_comb begin
    state_d = state_q;
    mask_d = busy ? {mask_q[0], mask_q[7:1]} : mask_q;
    idx_d = idx_q;
    data_err_d = 1'b0;
    last_err_d = 1'b0;
    pkt_end = 1'b0;
    case (state_q)
      IDLE: if (Enable) begin
        state_d = RECV;
        mask_d = READY_MASK;
        idx_d = '0;
      end
      RECV: if (hs) begin
        data_err_d = s.S_TData != exp_data;
        last_err_d = s.S_TLast ? !at_last : at_last;
        pkt_end = s.S_TLast;
        if (!s.S_TLast && at_last) state_d = RESYNC;
        else if (!s.S_TLast) idx_d = idx_q + IW'(1);
      end
      RESYNC: pkt_end = hs && s.S_TLast;
      DONE: if (!Enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pkt_inc = pkt_q + 16'(pkt_q != 16'hFFFF);
    err_sum = {1'b0, err_q} + 17'(data_err_d) + 17'(last_err_d);
    pkt_d = pkt_q;
    err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    if (pkt_end) begin
      pkt_d = pkt_inc;
      idx_d = '0;
      state_d = pkt_inc == 16'(NUM_PKTS) ? DONE : Enable ? RECV : IDLE;
    end
    if (state_q == IDLE && Enable) begin
      pkt_d = '0;
      err_d = '0;
    end
  end
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      mask_q <= READY_MASK;
      idx_q <= '0;
      pkt_q <= '0;
      err_q <= '0;
      data_err_q <= 1'b0;
      last_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      idx_q <= idx_d;
      pkt_q <= pkt_d;
      err_q <= err_d;
      data_err_q <= data_err_d;
      last_err_q <= last_err_d;
    end
  end
  assign PktCount = pkt_q;
  assign ErrCount = err_q;
  assign DataErr = data_err_q;
  assign LastErr = last_err_q;
  assign Busy = busy;
  assign Done = state_q == DONE;
endmodule

// File: tb/tb_axis_stream_checker.sv
// tb_axis_stream_checker: randomized packet traffic (good, early last, missing last, corrupt)
// checked cycle by cycle against a packet-level model of the checker.
module tb_axis_stream_checker;
  localparam int PL = 8;
  localparam int SEED = 2;
  localparam int NP = 6;
  localparam logic [7:0] RM = 8'hB5;
  typedef struct {
    logic [7:0] d;
    logic l;
    logic de;
    logic le;
  } beat_t;
  logic CLK = 1'b0;
  logic Reset_n = 1'b1;
  logic Enable = 1'b0;
  logic [15:0] pkt_count, err_count;
  logic data_err, last_err, busy, done;
  logic [7:0] rm = RM;
  beat_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int m_pkt, m_err, bcnt;
  logic m_busy, m_done, exp_de, exp_le;

  axis_stream_checker_if #(.WIDTH(8)) sif();

  axis_stream_checker #(
    .WIDTH(8), .PKT_LEN(PL), .SEED(SEED), .NUM_PKTS(NP), .READY_MASK(RM)
  ) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Enable(Enable), .s(sif),
    .PktCount(pkt_count), .ErrCount(err_count), .DataErr(data_err),
    .LastErr(last_err), .Busy(busy), .Done(done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, sif.S_TReady}, 0);
    chk({tag, "_pkt"}, {16'd0, pkt_count}, 0);
    chk({tag, "_err"}, {16'd0, err_count}, 0);
    chk({tag, "_derr"}, {31'd0, data_err}, 0);
    chk({tag, "_lerr"}, {31'd0, last_err}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
  endtask

  task automatic check_now();
    chk("DataErr", {31'd0, data_err}, {31'd0, exp_de});
    chk("LastErr", {31'd0, last_err}, {31'd0, exp_le});
    chk("PktCount", {16'd0, pkt_count}, m_pkt);
    chk("ErrCount", {16'd0, err_count}, m_err);
    chk("Busy", {31'd0, busy}, {31'd0, m_busy});
    chk("Done", {31'd0, done}, {31'd0, m_done});
    chk("S_TReady", {31'd0, sif.S_TReady}, {31'd0, m_busy ? rm[bcnt % 8] : 1'b0});
  endtask

  task automatic model_start();
    m_pkt = 0;
    m_err = 0;
    m_busy = 1'b1;
    m_done = 1'b0;
    bcnt = 0;
    exp_de = 1'b0;
    exp_le = 1'b0;
  endtask

  // kind: 0 good, 1 early last, 2 missing last (+1..3 beats), 3 one corrupted beat
  task automatic gen_pkt(input int kind);
    int n, bad;
    beat_t b;
    n = kind == 1 ? int'($urandom_range(1, PL - 1)) : kind == 2 ? PL + int'($urandom_range(1, 3)) : PL;
    bad = kind == 3 ? int'($urandom_range(0, PL - 1)) : -1;
    for (int i = 0; i < n; i++) begin
      b.d = i < PL ? 8'(SEED - i) : 8'($urandom);
      if (i == bad) b.d = b.d ^ 8'($urandom_range(1, 255));
      b.l = i == n - 1;
      b.de = i < PL && b.d != 8'(SEED - i);
      b.le = (b.l && i < PL - 1) || (!b.l && i == PL - 1);
      q.push_back(b);
    end
  endtask

  task automatic cycle();
    beat_t b;
    check_now();
    if (q.size() == 0) sif.S_TValid = 1'b0;
    else if (!sif.S_TValid) sif.S_TValid = $urandom_range(0, 3) != 0;
    if (q.size() != 0) begin
      sif.S_TData = q[0].d;
      sif.S_TLast = q[0].l;
    end
    exp_de = 1'b0;
    exp_le = 1'b0;
    if (m_busy) bcnt++;
    if (sif.S_TValid && sif.S_TReady) begin
      b = q.pop_front();
      exp_de = b.de;
      exp_le = b.le;
      m_err = m_err + int'(b.de) + int'(b.le) > 65535 ? 65535 : m_err + int'(b.de) + int'(b.le);
      if (b.l) begin
        m_pkt++;
        if (m_pkt == NP) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic run();
    int c = 0;
    while (q.size() != 0 && c < 2000) begin
      cycle();
      c++;
    end
    sif.S_TValid = 1'b0;
    check_now();
    chk("drained", q.size(), 0);
  endtask

  initial begin
    sif.S_TValid = 1'b1;
    sif.S_TData = 8'h5A;
    sif.S_TLast = 1'b1;
    #1 Reset_n = 1'b0;
    repeat (2) @(negedge CLK);
    check_zero("rst");
    Reset_n = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("idle_ready", {31'd0, sif.S_TReady}, 0);
      chk("idle_busy", {31'd0, busy}, 0);
    end
    Enable = 1'b1;
    @(negedge CLK);
    model_start();
    gen_pkt(0);
    gen_pkt(1);
    gen_pkt(2);
    gen_pkt(3);
    repeat (NP - 4) gen_pkt(int'($urandom_range(0, 3)));
    run();
    Enable = 1'b0;
    @(negedge CLK);
    chk("done_clear", {31'd0, done}, 0);
    chk("idle_busy2", {31'd0, busy}, 0);
    chk("pkt_hold", {16'd0, pkt_count}, NP);
    chk("err_hold", {16'd0, err_count}, m_err);
    Enable = 1'b1;
    @(negedge CLK);
    model_start();
    gen_pkt(0);
    while (q.size() > 3) void'(q.pop_back());
    run();
    #2 Reset_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);
    model_start();
    gen_pkt(0);
    gen_pkt(3);
    run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
